// File: rtl/fifo_row_assembler_if.sv
// fifo_row_assembler_if: beat-input and FIFO-write-port bundle for the row assembler.
interface fifo_row_assembler_if #(parameter int DWIDTH = 136);
  logic [15:0]       wdata_spi;
  logic              wvalid;
  logic              wready;
  logic              row_sync;
  logic [DWIDTH-1:0] fifo_wdata;
  logic              fifo_wr_en;
  logic              fifo_full;
  logic [3:0]        beat_cnt;
  logic              addr_err;
  logic              err_clr;
  modport master (
    output wdata_spi, wvalid, row_sync, fifo_full, err_clr,
    input  wready, fifo_wdata, fifo_wr_en, beat_cnt, addr_err
  );
  modport slave (
    input  wdata_spi, wvalid, row_sync, fifo_full, err_clr,
    output wready, fifo_wdata, fifo_wr_en, beat_cnt, addr_err
  );
endinterface

// File: rtl/fifo_row_assembler.sv
// fifo_row_assembler: rebuilds 136-bit rows from 16-bit beats and writes them to the sync FIFO.
// Define FIFO_ROW_ADDR_CHECK_EN to drop rows whose address beat bytes disagree and flag addr_err.
module fifo_row_assembler #(parameter int DWIDTH = 136) (
  input logic                 clk,
  input logic                 rst_n,
  fifo_row_assembler_if.slave bus
);
  if (DWIDTH != 136) begin : g_bad_width
    $error("fifo_row_assembler: DWIDTH must be 136");
  end
  logic [3:0]        beat_q, beat_d;
  logic [127:0]      asm_q, asm_d;
  logic [DWIDTH-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              wr_en, last, acc, addr_ok, load;
  logic [6:0]        hi_idx, lo_idx;
  assign wr_en       = out_valid_q && !bus.fifo_full;
  assign last        = beat_q == 4'd8;
  assign bus.wready  = !bus.row_sync && !(last && out_valid_q && !wr_en);
  assign acc         = bus.wvalid && bus.wready;
  assign load        = acc && last && addr_ok;
  // Beat k lands at bit 127-8k (tile 1) and 63-8k (tile 2) of the 128-bit data part.
  assign hi_idx      = {1'b1, ~beat_q[2:0], 3'b111};
  assign lo_idx      = {1'b0, ~beat_q[2:0], 3'b111};
  assign bus.fifo_wr_en = wr_en;
  assign bus.fifo_wdata = out_q;
  assign bus.beat_cnt   = beat_q;
  always_comb begin
    beat_d      = beat_q;
    asm_d       = asm_q;
    out_d       = out_q;
    out_valid_d = out_valid_q && !wr_en;
    if (bus.row_sync) begin
      beat_d = '0;
      asm_d  = '0;
    end else if (acc) begin
      beat_d = last ? 4'd0 : beat_q + 4'd1;
      if (!last) begin
        asm_d[hi_idx -: 8] = bus.wdata_spi[15:8];
        asm_d[lo_idx -: 8] = bus.wdata_spi[7:0];
      end
    end
    if (load) begin
      out_d       = {asm_q, bus.wdata_spi[15:8]};
      out_valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q      <= '0;
      asm_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      beat_q      <= beat_d;
      asm_q       <= asm_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end
`ifdef FIFO_ROW_ADDR_CHECK_EN
  logic err_q, err_d;
  assign addr_ok      = bus.wdata_spi[15:8] == bus.wdata_spi[7:0];
  assign err_d        = (acc && last && !addr_ok) || (err_q && !bus.err_clr);
  assign bus.addr_err = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  assign addr_ok      = 1'b1;
  assign bus.addr_err = 1'b0;
`endif
endmodule
